bus_mem_responder: RTL and testbench

Memory-side slave on the shared CPU bus, downstream of each CPU's bus bridge. Watches `read_q`/`write_q` while a CPU owns the bus (`bus_busy` high) and services reads and writes against a local word array after a fixed, parameterised latency. Answers with `read_dn`/`write_dn` under a four-phase handshake, and returns read data on a split data port that the top level merges onto the tri-state `data` bus.

---
 rtl/bus_mem_responder_pkg.sv | 25 ++
 rtl/bus_mem_responder_array.sv | 37 +++
 rtl/bus_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_bus_mem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_mem_responder_pkg
// Shared definitions for the bus memory responder: FSM state encoding,
// latency counter width and a helper that turns a latency parameter into
// the counter preload value.
// -----------------------------------------------------------------------------
package bus_mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        BMR_IDLE    = 3'd0,
        BMR_RD_WAIT = 3'd1,
        BMR_WR_WAIT = 3'd2,
        BMR_RD_ACK  = 3'd3,
        BMR_WR_ACK  = 3'd4
    } bmr_state_t;

    // The counter ends its wait phase when it reaches zero, so a latency of
    // N cycles from accept preloads N-1.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/bus_mem_responder_array.sv
// -----------------------------------------------------------------------------
// bus_mem_array
// 2^DEPTH_LOG2 x DATA_W word storage with a synchronous write port and a
// registered read port. Contents are not reset.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_we     - write enable
//   i_waddr  - write word index
//   i_wdata  - write data
//   i_raddr  - read word index, captured every cycle
//   o_rdata  - registered read data (word at i_raddr one edge earlier)
// -----------------------------------------------------------------------------
module bus_mem_array
    import bus_mem_responder_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
// Memory-side slave on the shared CPU bus. Accepts a read or write while
// the bus is owned, services it against a local word array after a fixed
// latency and acknowledges with a four-phase read_dn/write_dn handshake.
// Read data leaves on a split port; o_data_oe enables the top-level
// tri-state driver.
//
// Optional feature macro: BUS_MEM_BOUNDS_CHK_EN
//   defined   - accepted addresses with nonzero bits above DEPTH_LOG2 still
//               complete the handshake, but reads return 0, writes are
//               dropped and o_err is set.
//   undefined - upper address bits are ignored (addresses alias).
//
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - synchronous active-low reset
//   i_bus_busy  - a CPU owns the bus
//   i_addr      - word address
//   i_data      - write data
//   i_read_q    - read request
//   i_write_q   - write request
//   o_data      - read data, holds after o_data_oe drops
//   o_data_oe   - data bus drive enable
//   o_read_dn   - read complete
//   o_write_dn  - write complete
//   o_err       - sticky protocol error
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a request while the bus is owned
// RD_WAIT  | read accepted, counting down the read latency
// WR_WAIT  | write accepted, counting down the write latency
// RD_ACK   | read_dn/data_oe held until read_q drops
// WR_ACK   | write_dn held until write_q drops
// -----------------------------------------------------------------------------
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 2,
    parameter int WR_LAT     = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bus_busy,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_read_q,
    input  logic              i_write_q,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_oe,
    output logic              o_read_dn,
    output logic              o_write_dn,
    output logic              o_err
);

    bmr_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_oob;

    logic                  w_oob;
    logic                  w_we;
    logic                  w_wr_done;
    logic [DEPTH_LOG2-1:0] w_raddr;
    logic [DATA_W-1:0]     w_rd_data;

`ifdef BUS_MEM_BOUNDS_CHK_EN
    assign w_oob = |i_addr[ADDR_W-1:DEPTH_LOG2];
`else
    logic w_unused_addr_hi;
    assign w_oob            = 1'b0;
    assign w_unused_addr_hi = ^i_addr[ADDR_W-1:DEPTH_LOG2];
`endif

    // The array read port is registered, so present the incoming address
    // while idle: the word is then ready one edge after accept, which covers
    // the shortest read latency.
    assign w_raddr = (r_state == BMR_IDLE) ? i_addr[DEPTH_LOG2-1:0] : r_addr;

    // Commit only on the completing edge of a write that is not being
    // aborted or reset on that same edge.
    assign w_wr_done = (r_state == BMR_WR_WAIT) && (r_cnt == '0) &&
                       i_bus_busy && i_write_q && i_rst;
    assign w_we      = w_wr_done && !r_oob;

    bus_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= BMR_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_oob      <= 1'b0;
            o_data     <= '0;
            o_data_oe  <= 1'b0;
            o_read_dn  <= 1'b0;
            o_write_dn <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            case (r_state)
                BMR_IDLE: begin
                    if (i_read_q && i_write_q) begin
                        o_err <= 1'b1;
                    end else if (i_bus_busy && i_read_q) begin
                        r_addr  <= i_addr[DEPTH_LOG2-1:0];
                        r_oob   <= w_oob;
                        r_cnt   <= lat_load(RD_LAT);
                        r_state <= BMR_RD_WAIT;
                        if (w_oob) o_err <= 1'b1;
                    end else if (i_bus_busy && i_write_q) begin
                        r_addr  <= i_addr[DEPTH_LOG2-1:0];
                        r_wdata <= i_data;
                        r_oob   <= w_oob;
                        r_cnt   <= lat_load(WR_LAT);
                        r_state <= BMR_WR_WAIT;
                        if (w_oob) o_err <= 1'b1;
                    end
                end
                BMR_RD_WAIT: begin
                    if (!i_bus_busy || !i_read_q) begin
                        r_state <= BMR_IDLE;
                    end else if (r_cnt == '0) begin
                        o_data    <= r_oob ? '0 : w_rd_data;
                        o_data_oe <= 1'b1;
                        o_read_dn <= 1'b1;
                        r_state   <= BMR_RD_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                BMR_WR_WAIT: begin
                    if (!i_bus_busy || !i_write_q) begin
                        r_state <= BMR_IDLE;
                    end else if (r_cnt == '0) begin
                        o_write_dn <= 1'b1;
                        r_state    <= BMR_WR_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                BMR_RD_ACK: begin
                    if (!i_read_q) begin
                        o_read_dn <= 1'b0;
                        o_data_oe <= 1'b0;
                        r_state   <= BMR_IDLE;
                    end
                end
                BMR_WR_ACK: begin
                    if (!i_write_q) begin
                        o_write_dn <= 1'b0;
                        r_state    <= BMR_IDLE;
                    end
                end
                default: r_state <= BMR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 8;
    localparam int RD_LAT     = 2;
    localparam int WR_LAT     = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              bus_busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_i;
    logic              read_q;
    logic              write_q;
    logic [DATA_W-1:0] data_o;
    logic              data_oe;
    logic              read_dn;
    logic              write_dn;
    logic              err;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_bus_busy (bus_busy),
        .i_addr     (addr),
        .i_data     (data_i),
        .i_read_q   (read_q),
        .i_write_q  (write_q),
        .o_data     (data_o),
        .o_data_oe  (data_oe),
        .o_read_dn  (read_dn),
        .o_write_dn (write_dn),
        .o_err      (err)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Expected output values after the most recent rising edge.
    logic [DATA_W-1:0] exp_data;
    logic              exp_oe, exp_rdn, exp_wdn, exp_err;

    // Reference memory, indexed by word index.
    logic [DATA_W-1:0] mem_m [int];
    logic [7:0]        written [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("read_dn",  32'(read_dn),  32'(exp_rdn));
            chk("write_dn", 32'(write_dn), 32'(exp_wdn));
            chk("data_oe",  32'(data_oe),  32'(exp_oe));
            chk("data_o",   data_o,        exp_data);
            chk("err",      32'(err),      32'(exp_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit oob(input logic [ADDR_W-1:0] a);
`ifdef BUS_MEM_BOUNDS_CHK_EN
        return (a >> DEPTH_LOG2) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        if (oob(a)) return '0;
        return mem_m[int'(a % (1 << DEPTH_LOG2))];
    endfunction

    task automatic reset_expect();
        exp_data = '0; exp_oe = 1'b0; exp_rdn = 1'b0; exp_wdn = 1'b0; exp_err = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input int hold);
        bus_busy = 1'b1; addr = a; read_q = 1'b1;
        tick();                             // accept edge N
        if (oob(a)) exp_err = 1'b1;
        repeat (RD_LAT - 1) tick();
        tick();                             // edge N+RD_LAT
        exp_rdn = 1'b1; exp_oe = 1'b1; exp_data = model_rd(a);
        repeat (hold) tick();
        read_q = 1'b0;
        tick();                             // release edge M
        exp_rdn = 1'b0; exp_oe = 1'b0;
        bus_busy = 1'b0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int hold);
        bus_busy = 1'b1; addr = a; data_i = d; write_q = 1'b1;
        tick();
        if (oob(a)) exp_err = 1'b1;
        repeat (WR_LAT - 1) tick();
        tick();                             // edge N+WR_LAT: commit
        exp_wdn = 1'b1;
        if (!oob(a)) begin
            mem_m[int'(a % (1 << DEPTH_LOG2))] = d;
            written.push_back(a[7:0]);
        end
        repeat (hold) tick();
        write_q = 1'b0;
        tick();
        exp_wdn = 1'b0;
        bus_busy = 1'b0;
    endtask

    task automatic rd_abort(input logic [ADDR_W-1:0] a, input int j, input bit by_bb);
        bus_busy = 1'b1; addr = a; read_q = 1'b1;
        tick();
        if (oob(a)) exp_err = 1'b1;
        repeat (j) tick();
        if (by_bb) bus_busy = 1'b0; else read_q = 1'b0;
        tick();                             // aborted, no dn
        read_q = 1'b0; bus_busy = 1'b0;
    endtask

    task automatic wr_abort(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int j, input bit by_bb);
        bus_busy = 1'b1; addr = a; data_i = d; write_q = 1'b1;
        tick();
        if (oob(a)) exp_err = 1'b1;
        repeat (j) tick();
        if (by_bb) bus_busy = 1'b0; else write_q = 1'b0;
        tick();
        write_q = 1'b0; bus_busy = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [23:0]       hi;
        int                kind;

        rst = 1'b0; bus_busy = 1'b0; addr = '0; data_i = '0; read_q = 1'b0; write_q = 1'b0;
        reset_expect();
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Write then read back.
        wr(32'h05, 32'hDEADBEEF, 2);
        rd(32'h05, 1);
        chk("lit_rd05", data_o, 32'hDEADBEEF);

        // Back-to-back write/read with a single idle cycle between.
        wr(32'h00, 32'h11, 0);
        rd(32'h00, 0);
        chk("lit_b2b", data_o, 32'h11);

        // Aborted write leaves old contents.
        wr(32'h03, 32'h77, 0);
        wr_abort(32'h03, 32'h22, 0, 1'b0);
        tick();
        rd(32'h03, 0);
        chk("lit_abort", data_o, 32'h77);

        // Simultaneous requests: sticky error, no ack, cleared by reset.
        bus_busy = 1'b1; addr = 32'h05; read_q = 1'b1; write_q = 1'b1;
        tick();
        exp_err = 1'b1;
        tick(); tick();
        read_q = 1'b0; write_q = 1'b0; bus_busy = 1'b0;
        tick();
        chk("lit_err_set", 32'(err), 32'd1);
        rst = 1'b0;
        tick();
        reset_expect();
        rst = 1'b1;
        chk("lit_err_clr", 32'(err), 32'd0);
        tick();

        // Upper address bits.
        rd(32'h105, 0);
`ifdef BUS_MEM_BOUNDS_CHK_EN
        chk("lit_oob_data", data_o, 32'h0);
        chk("lit_oob_err", 32'(err), 32'd1);
`else
        chk("lit_alias", data_o, 32'hDEADBEEF);
`endif

        // Reset while in the read acknowledge phase.
        bus_busy = 1'b1; addr = 32'h00; read_q = 1'b1;
        tick();
        repeat (RD_LAT) tick();
        exp_rdn = 1'b1; exp_oe = 1'b1; exp_data = model_rd(32'h00);
        tick();
        rst = 1'b0;
        tick();
        reset_expect();
        chk("lit_rst_ack_dn", 32'(read_dn), 32'd0);
        chk("lit_rst_ack_oe", 32'(data_oe), 32'd0);
        rst = 1'b1; read_q = 1'b0; bus_busy = 1'b0;
        rd(32'h05, 0);
        chk("lit_after_rst", data_o, 32'hDEADBEEF);

        // Reset on the committing edge of a write.
        wr(32'h09, 32'hAAAA, 0);
        bus_busy = 1'b1; addr = 32'h09; data_i = 32'h5555; write_q = 1'b1;
        repeat (WR_LAT) tick();
        rst = 1'b0;
        tick();
        reset_expect();
        rst = 1'b1; write_q = 1'b0; bus_busy = 1'b0;
        tick();
        rd(32'h09, 0);
        chk("lit_rst_wr", data_o, 32'hAAAA);

        // Randomised transactions.
        for (int t = 0; t < 120; t++) begin
            kind = int'($urandom_range(0, 9));
            hi = ($urandom_range(0, 7) == 0) ? 24'($urandom_range(1, 15)) : 24'h0;
            if (kind <= 3) begin
                a = {hi, 8'($urandom_range(0, 255))};
                if ($urandom_range(0, 4) == 0) wr_abort(a, $urandom, int'($urandom_range(0, WR_LAT - 1)), 1'($urandom_range(0, 1)));
                else wr(a, $urandom, int'($urandom_range(0, 3)));
            end else begin
                a = {hi, written[$urandom_range(0, written.size() - 1)]};
                if (kind == 9) rd_abort(a, int'($urandom_range(0, RD_LAT - 1)), 1'($urandom_range(0, 1)));
                else rd(a, int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick(); tick();
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
